// File: rtl/data_memory_responder.sv
// data_memory_responder
// Doubleword-organised data memory answering one load or store at a time
// after a programmable number of wait states.
//
// Parameters:
//   ADDR_SIZE   - log2 of the number of 64-bit doublewords stored
//   WAIT_CYCLES - extra wait states before each response (0..15)
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   rd_enable  - load request strobe (sampled in IDLE only)
//   wr_enable  - store request strobe (sampled in IDLE only)
//   size       - access width: 0 byte, 1 halfword, 2 word, 3 doubleword
//   address    - byte address
//   write_data - store data, right-justified
//   read_data  - load data, right-justified, zero-extended
//   busy       - request in flight
//   ack        - one-cycle completion pulse
//   error      - failed request, qualified by ack
//
// Configuration macro:
//   DMEM_MISALIGN_TRAP_EN - when defined, misaligned accesses complete with
//                           error; otherwise the low address bits are forced
//                           to zero and the access proceeds aligned.
module data_memory_responder #(
    parameter int unsigned ADDR_SIZE   = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_enable,
    input  logic        wr_enable,
    input  logic [1:0]  size,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        busy,
    output logic        ack,
    output logic        error
);

    localparam int unsigned DEPTH   = 1 << ADDR_SIZE;
    localparam int unsigned TOP_BIT = ADDR_SIZE + 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic [63:0]        wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [63:0]        read_data_q, read_data_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               error_q, error_d;

    logic [63:0]        mem_q [DEPTH];

    logic [2:0]         align_mask_c;
    logic [63:0]        width_mask_c;
    logic [7:0]         lane_base_c;
    logic [2:0]         offset_c;
    logic [5:0]         shift_c;
    logic               range_err_c;
    logic               acc_err_c;
    logic               access_c;
    logic               mem_we_c;
    logic [ADDR_SIZE-1:0] idx_c;
    logic [63:0]        load_val_c;
    logic [63:0]        store_data_c;
    logic [7:0]         byte_en_c;

    // Width-dependent masks for the captured request
    always_comb begin
        case (size_q)
            2'd0:    begin align_mask_c = 3'b000; width_mask_c = 64'h0000_0000_0000_00FF; lane_base_c = 8'h01; end
            2'd1:    begin align_mask_c = 3'b001; width_mask_c = 64'h0000_0000_0000_FFFF; lane_base_c = 8'h03; end
            2'd2:    begin align_mask_c = 3'b011; width_mask_c = 64'h0000_0000_FFFF_FFFF; lane_base_c = 8'h0F; end
            default: begin align_mask_c = 3'b111; width_mask_c = 64'hFFFF_FFFF_FFFF_FFFF; lane_base_c = 8'hFF; end
        endcase
    end

    // Any address bit above the array is out of range
    assign range_err_c = |(addr_q >> TOP_BIT);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign offset_c  = addr_q[2:0];
    assign acc_err_c = range_err_c | (|(addr_q[2:0] & align_mask_c));
`else
    assign offset_c  = addr_q[2:0] & ~align_mask_c;
    assign acc_err_c = range_err_c;
`endif

    assign idx_c        = addr_q[ADDR_SIZE+2:3];
    assign shift_c      = {offset_c, 3'b000};
    assign load_val_c   = (mem_q[idx_c] >> shift_c) & width_mask_c;
    assign store_data_c = (wdata_q & width_mask_c) << shift_c;
    assign byte_en_c    = lane_base_c << offset_c;
    assign access_c     = (state_q == S_WAIT) && (cnt_q == '0);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rd_enable && wr_enable) begin
                    state_d = S_RESPOND;
                end else if (rd_enable || wr_enable) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        busy_d      = (state_d != S_IDLE);
        ack_d       = 1'b0;
        error_d     = 1'b0;
        mem_we_c    = 1'b0;

        if (state_q == S_IDLE && (rd_enable ^ wr_enable)) begin
            addr_d  = address;
            size_d  = size;
            wdata_d = write_data;
            is_wr_d = wr_enable;
        end

        // Conflicting strobes answer immediately without touching memory
        if (state_q == S_IDLE && rd_enable && wr_enable) begin
            ack_d   = 1'b1;
            error_d = 1'b1;
        end

        if (access_c) begin
            ack_d   = 1'b1;
            error_d = acc_err_c;
            if (!acc_err_c) begin
                if (is_wr_q) begin
                    mem_we_c = 1'b1;
                end else begin
                    read_data_d = load_val_c;
                end
            end
        end
    end

    // Registered outputs and captured request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            error_q     <= error_d;
        end
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= store_data_c[8*i +: 8];
                end
            end
        end
    end

    assign read_data = read_data_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign error     = error_q;

endmodule
